avln_st_pkt_gen: RTL and testbench

AVLN_ST_PKT_GEN -- requirements
Module: avln_st_pkt_gen

---
 rtl/global_types.sv | 28 ++
 rtl/lfsr32.sv | 34 +++
 rtl/avln_st_pkt_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_avln_st_pkt_gen.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_types.sv
// Shared types for the Avalon-ST packet generator.
//   gen_mode_e  : payload mode selector (INCR, LFSR, CONST, TAG)
//   gen_state_e : generator FSM state encoding
//   lfsr32_next : one step of the 32-bit Galois LFSR, x^32+x^22+x^2+x+1
package global_types;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_TAG   = 2'd3
  } gen_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_e;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  // Right-shifting Galois form: taps at x^32, x^22, x^2 and x^1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR that steps only when advance is high.
// Ports:
//   clk      in   clock, posedge
//   reset_n  in   synchronous active-low reset, reloads the seed
//   advance  in   step the register this cycle
//   value    out  current LFSR contents
module lfsr32
  import global_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  // NOTE: every signal written in always_comb gets a value on every path
  // (default first) so no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr32_next(value_q);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values of its sources.
  always_ff @(posedge clk) begin
    if (!reset_n) value_q <= LFSR_SEED;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/avln_st_pkt_gen.sv
// Avalon-ST packet generator with round-robin channel selection.
// Packets of max(pkt_len,1) bytes are emitted as ceil(L/SYMBOLS) beats, followed
// by 'gap' idle cycles. Parameters are latched when a packet starts.
// Ports:
//   sys_clk, reset_n        clock / synchronous active-low reset
//   enable                  start or keep generating packets
//   mode                    payload mode (INCR, LFSR, CONST, TAG)
//   pkt_len, gap            packet length in bytes, idle cycles after a packet
//   ch_mask                 channels eligible for round-robin
//   const_word              payload for CONST mode
//   out_ready               sink backpressure
//   out_valid/sop/eop/data/empty/channel   registered Avalon-ST source
//   pkt_count               packets whose eop beat has transferred
//   busy                    FSM not in IDLE
module avln_st_pkt_gen
  import global_types::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int N_CH    = 4,
  parameter  int LEN_W   = 16,
  localparam int SYMBOLS = DATA_W / 8,
  localparam int EMPTY_W = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic [7:0]         gap,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DATA_W-1:0]  const_word,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [CH_W-1:0]    out_channel,
  output logic [31:0]        pkt_count,
  output logic               busy
);

  gen_state_e         state_q, state_d;
  gen_mode_e          mode_q, mode_d;
  logic [LEN_W-1:0]   beat_idx_q, beat_idx_d, last_idx_q, last_idx_d;
  logic [EMPTY_W-1:0] empty_last_q, empty_last_d;
  logic [7:0]         gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0]  const_word_q, const_word_d;
  logic [CH_W-1:0]    ch_q, ch_d, rr_ptr_q, rr_ptr_d;
  logic [31:0]        incr_q, incr_d, pkt_count_q, pkt_count_d;
  logic               out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic [CH_W-1:0]    out_channel_q, out_channel_d;

  logic               xfer, start_ok, start_pkt, next_beat, drop;
  logic [CH_W-1:0]    pick_ch;
  logic [LEN_W-1:0]   eff_len;
  logic [31:0]        lfsr_val, lfsr_nxt;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    return (c == CH_W'(N_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  // First eligible channel at or after ptr, wrapping around the mask.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] mask,
                                               input logic [CH_W-1:0] ptr);
    logic [N_CH-1:0] rot;
    logic [CH_W:0]   s;
    logic            found;
    rot     = N_CH'({mask, mask} >> ptr);
    found   = 1'b0;
    rr_pick = ptr;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        s = {1'b0, ptr} + (CH_W + 1)'(i);
        if (s >= (CH_W + 1)'(N_CH)) s = s - (CH_W + 1)'(N_CH);
        rr_pick = s[CH_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [DATA_W-1:0] beat_payload(
    input gen_mode_e m, input logic [CH_W-1:0] ch, input logic [LEN_W-1:0] idx,
    input logic [DATA_W-1:0] cw, input logic [31:0] incr, input logic [31:0] lfsr);
    logic [DATA_W-1:0] p;
    p = '0;
    case (m)
      MODE_INCR:  p = DATA_W'(incr);
      MODE_LFSR:  for (int i = 0; i < DATA_W; i++) p[i] = lfsr[i % 32];
      MODE_CONST: p = cw;
      MODE_TAG: begin
        p = DATA_W'(idx);
        p[DATA_W-1 -: 8] = 8'(ch);
      end
      default:    p = '0;
    endcase
    return p;
  endfunction

  lfsr32 u_lfsr (
    .clk     (sys_clk),
    .reset_n (reset_n),
    .advance (xfer),
    .value   (lfsr_val)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    beat_idx_d    = beat_idx_q;
    last_idx_d    = last_idx_q;
    empty_last_d  = empty_last_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    const_word_d  = const_word_q;
    ch_d          = ch_q;
    rr_ptr_d      = rr_ptr_q;
    pkt_count_d   = pkt_count_q;
    out_valid_d   = out_valid_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_data_d    = out_data_q;
    out_empty_d   = out_empty_q;
    out_channel_d = out_channel_q;
    start_pkt     = 1'b0;
    next_beat     = 1'b0;
    drop          = 1'b0;

    xfer     = out_valid_q & out_ready;
    start_ok = enable & (|ch_mask);
    pick_ch  = rr_pick(ch_mask, rr_ptr_q);
    eff_len  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    // Beat counter and LFSR as they will read once this cycle's transfer lands;
    // a beat loaded now is presented with these values.
    incr_d   = incr_q + 32'(xfer);
    lfsr_nxt = xfer ? lfsr32_next(lfsr_val) : lfsr_val;

    case (state_q)
      ST_IDLE: if (start_ok) start_pkt = 1'b1;
      ST_SEND: begin
        if (xfer) begin
          if (beat_idx_q == last_idx_q) begin
            pkt_count_d = pkt_count_q + 1'b1;
            if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              drop      = 1'b1;
            end else if (start_ok) begin
              start_pkt = 1'b1;
            end else begin
              state_d = ST_IDLE;
              drop    = 1'b1;
            end
          end else begin
            next_beat = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          if (start_ok) start_pkt = 1'b1;
          else          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_pkt) begin
      state_d      = ST_SEND;
      mode_d       = gen_mode_e'(mode);
      gap_d        = gap;
      const_word_d = const_word;
      ch_d         = pick_ch;
      rr_ptr_d     = ch_inc(pick_ch);
      beat_idx_d   = '0;
      last_idx_d   = LEN_W'((eff_len - 1) / SYMBOLS);
      empty_last_d = EMPTY_W'(SYMBOLS - 1 - ((eff_len - 1) % SYMBOLS));
    end
    if (next_beat) beat_idx_d = beat_idx_q + 1'b1;

    if (start_pkt || next_beat) begin
      out_valid_d   = 1'b1;
      out_sop_d     = (beat_idx_d == '0);
      out_eop_d     = (beat_idx_d == last_idx_d);
      out_empty_d   = out_eop_d ? empty_last_d : '0;
      out_channel_d = ch_d;
      out_data_d    = beat_payload(mode_d, ch_d, beat_idx_d, const_word_d, incr_d, lfsr_nxt);
    end else if (drop) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_empty_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_INCR;
      beat_idx_q    <= '0;
      last_idx_q    <= '0;
      empty_last_q  <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      const_word_q  <= '0;
      ch_q          <= '0;
      rr_ptr_q      <= '0;
      incr_q        <= '0;
      pkt_count_q   <= '0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_data_q    <= '0;
      out_empty_q   <= '0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      beat_idx_q    <= beat_idx_d;
      last_idx_q    <= last_idx_d;
      empty_last_q  <= empty_last_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      const_word_q  <= const_word_d;
      ch_q          <= ch_d;
      rr_ptr_q      <= rr_ptr_d;
      incr_q        <= incr_d;
      pkt_count_q   <= pkt_count_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_data_q    <= out_data_d;
      out_empty_q   <= out_empty_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_data    = out_data_q;
  assign out_empty   = out_empty_q;
  assign out_channel = out_channel_q;
  assign pkt_count   = pkt_count_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avln_st_pkt_gen.sv
// Scoreboard bench for avln_st_pkt_gen (DATA_W=32, N_CH=4, LEN_W=16).
// Expected beats are pushed when a batch of packets is requested and popped
// by a negedge monitor on every transfer.
module tb_avln_st_pkt_gen;

  localparam int DATA_W  = 32;
  localparam int N_CH    = 4;
  localparam int LEN_W   = 16;
  localparam int SYMBOLS = 4;
  localparam int EMPTY_W = 2;
  localparam int CH_W    = 2;

  logic              sys_clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  pkt_len;
  logic [7:0]        gap;
  logic [N_CH-1:0]   ch_mask;
  logic [DATA_W-1:0] const_word;
  logic              out_ready;
  logic              out_valid, out_sop, out_eop, busy;
  logic [DATA_W-1:0] out_data;
  logic [EMPTY_W-1:0] out_empty;
  logic [CH_W-1:0]   out_channel;
  logic [31:0]       pkt_count;

  always #5 sys_clk = ~sys_clk;

  avln_st_pkt_gen #(.DATA_W(DATA_W), .N_CH(N_CH), .LEN_W(LEN_W)) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .pkt_len     (pkt_len),
    .gap         (gap),
    .ch_mask     (ch_mask),
    .const_word  (const_word),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_data    (out_data),
    .out_empty   (out_empty),
    .out_channel (out_channel),
    .pkt_count   (pkt_count),
    .busy        (busy)
  );

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [CH_W-1:0]    ch;
    logic [DATA_W-1:0]  data;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_incr;
  logic [31:0] m_lfsr;
  int          m_ptr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return v;
  endfunction

  task automatic push_pkts(input int n);
    beat_t           b;
    logic [N_CH-1:0] sh;
    int              c, len, nb;
    bit              found;
    for (int p = 0; p < n; p++) begin
      found = 0;
      c     = 0;
      for (int i = 0; i < N_CH; i++) begin
        sh = ch_mask >> ((m_ptr + i) % N_CH);
        if (!found && sh[0]) begin
          c     = (m_ptr + i) % N_CH;
          found = 1;
        end
      end
      m_ptr = (c + 1) % N_CH;
      len   = (pkt_len == 0) ? 1 : int'(pkt_len);
      nb    = (len + SYMBOLS - 1) / SYMBOLS;
      for (int k = 0; k < nb; k++) begin
        b.sop   = (k == 0);
        b.eop   = (k == nb - 1);
        b.empty = b.eop ? EMPTY_W'(nb * SYMBOLS - len) : '0;
        b.ch    = CH_W'(c);
        case (mode)
          2'd0:    b.data = m_incr;
          2'd1:    b.data = m_lfsr;
          2'd2:    b.data = const_word;
          default: b.data = {8'(c), 24'(k)};
        endcase
        exp_q.push_back(b);
        m_incr = m_incr + 1;
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  endtask

  // Sink backpressure: always ready unless the stall pattern 1,0,0,1 is on.
  logic       bp_en = 1'b0;
  logic [1:0] bp_k  = '0;
  logic [3:0] bp_pat = 4'b1001;
  initial out_ready = 1'b1;
  always @(posedge sys_clk) begin
    #1;
    if (bp_en) begin
      out_ready = bp_pat[bp_k];
      bp_k      = bp_k + 1'b1;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: scoreboard compare, hold-while-stalled, pkt_count tracking.
  logic                          mon_en = 1'b0;
  logic                          prev_stall;
  logic [DATA_W+CH_W+EMPTY_W+2:0] snap, prev_snap;
  int                            exp_pkts;
  beat_t                         mb;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      snap = {out_valid, out_sop, out_eop, out_empty, out_channel, out_data};
      if (prev_stall) check("hold_while_stalled", 64'(snap), 64'(prev_snap));
      check("pkt_count", pkt_count, exp_pkts);
      if (out_valid && out_ready) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mb = exp_q.pop_front();
          check("sop",     out_sop,     mb.sop);
          check("eop",     out_eop,     mb.eop);
          check("empty",   out_empty,   mb.empty);
          check("channel", out_channel, mb.ch);
          check("data",    out_data,    mb.data);
        end
        if (out_eop) exp_pkts++;
      end
      prev_stall = out_valid && !out_ready;
      prev_snap  = snap;
    end else begin
      prev_stall = 1'b0;
      exp_pkts   = 0;
    end
  end

  task automatic model_reset();
    m_incr = 32'h0;
    m_lfsr = 32'h1;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    enable  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge sys_clk);
    mon_en = 1'b1;
  endtask

  // Run n packets with the current settings; enable drops on the last eop.
  task automatic send_pkts(input int n);
    int eops = 0, idle = 0, cyc = 0;
    bit started = 0;
    push_pkts(n);
    enable = 1'b1;
    while (eops < n && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
      if (started && !out_valid) idle++;
      if (out_valid) started = 1;
      if (out_valid && out_ready && out_eop) begin
        eops++;
        if (eops == n) enable = 1'b0;
      end
    end
    check("pkts_done", eops, n);
    check("gap_cycles", idle, int'(gap) * (n - 1));
    repeat (int'(gap) + 3) @(negedge sys_clk);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  beats, cyc;
    bit  done;
    reset_n    = 1'b0;
    enable     = 1'b0;
    mode       = 2'd0;
    pkt_len    = 16'd10;
    gap        = 8'd0;
    ch_mask    = 4'b0001;
    const_word = 32'hA5C3_0F96;
    @(negedge sys_clk);
    do_reset();

    @(negedge sys_clk);
    check("rst_valid",     out_valid,   0);
    check("rst_sop",       out_sop,     0);
    check("rst_eop",       out_eop,     0);
    check("rst_data",      out_data,    0);
    check("rst_empty",     out_empty,   0);
    check("rst_channel",   out_channel, 0);
    check("rst_pkt_count", pkt_count,   0);
    check("rst_busy",      busy,        0);

    // INCR, 10 bytes: 3 beats, empty 2, back-to-back packets
    mode = 2'd0; pkt_len = 16'd10; gap = 8'd0; ch_mask = 4'b0001;
    send_pkts(2);

    // TAG mode, round-robin over channels 1 and 3
    mode = 2'd3; pkt_len = 16'd8; gap = 8'd0; ch_mask = 4'b1010;
    send_pkts(4);

    // LFSR, single-beat packets separated by 3 idle cycles
    mode = 2'd1; pkt_len = 16'd4; gap = 8'd3; ch_mask = 4'b0001;
    send_pkts(3);

    // CONST, odd length, all channels, 1-cycle gap
    mode = 2'd2; pkt_len = 16'd7; gap = 8'd1; ch_mask = 4'b1111;
    send_pkts(3);

    // Backpressure pattern 1,0,0,1 during 4-beat INCR packets
    bp_en = 1'b1;
    mode = 2'd0; pkt_len = 16'd16; gap = 8'd0; ch_mask = 4'b0001;
    send_pkts(2);
    bp_en = 1'b0;

    // enable dropped on beat 1 of a 4-beat packet
    mode = 2'd0; pkt_len = 16'd16; gap = 8'd0; ch_mask = 4'b0100;
    push_pkts(1);
    enable = 1'b1;
    beats = 0; cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
      if (out_valid && out_ready) begin
        if (beats == 1) enable = 1'b0;
        if (out_eop) done = 1;
        beats++;
      end
    end
    check("drop_beats", beats, 4);
    repeat (3) @(negedge sys_clk);
    check("drop_busy", busy, 0);
    check("drop_valid", out_valid, 0);
    check("drop_queue", exp_q.size(), 0);

    // pkt_len=0 behaves as one byte: single beat, empty 3
    pkt_len = 16'd0;
    send_pkts(1);

    // Reset on beat 2 of an LFSR packet
    mode = 2'd1; pkt_len = 16'd16; gap = 8'd0; ch_mask = 4'b0001;
    push_pkts(1);
    enable = 1'b1;
    beats = 0; cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
      if (out_valid && out_ready) begin
        if (beats == 2) begin
          reset_n = 1'b0;
          enable  = 1'b0;
          mon_en  = 1'b0;
          done    = 1;
        end
        beats++;
      end
    end
    check("reset_reached_beat2", beats, 3);
    @(negedge sys_clk);
    check("mid_rst_valid",     out_valid, 0);
    check("mid_rst_eop",       out_eop,   0);
    check("mid_rst_pkt_count", pkt_count, 0);
    check("mid_rst_busy",      busy,      0);
    check("mid_rst_data",      out_data,  0);
    reset_n = 1'b1;
    model_reset();
    @(posedge sys_clk);
    mon_en = 1'b1;

    // LFSR restarts from seed; round-robin restarts from channel 0
    ch_mask = 4'b0110;
    send_pkts(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
